// File: rtl/mem_line_responder_pkg.sv
// Shared line-level types for the cache memory port and its responder.
package mem_line_responder_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_SHIFT = 4;

    typedef logic [LINE_BYTES*8-1:0] line_t;
    typedef logic [LINE_BYTES-1:0]   line_be_t;

endpackage

// File: rtl/mem_line_responder_line_ram.sv
// DEPTH x 128-bit line store with byte-lane write enables and a registered read port.
module line_ram
    import mem_line_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [IW-1:0] addr,
    input  logic          rd_en,
    input  logic          wr_en,
    input  line_t         wr_data,
    input  line_be_t      wr_be,
    output line_t         rd_data
);

    line_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[addr];
        end
        if (wr_en) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Avalon-MM slave serving 128-bit cache lines with programmable wait states,
// byte-enabled writes and a sticky protocol-error flag.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int          DEPTH   = 256,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] avl_address,
    input  logic        avl_read,
    input  logic        avl_write,
    input  line_t       avl_writedata,
    input  line_be_t    avl_byteenable,
    output line_t       avl_readdata,
    output logic        avl_waitrequest,
    output logic        err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          err_next;
    logic          accept;
    logic          req;

    logic          op_write;
    logic          in_range_q;
    logic [IW-1:0] idx_q;
    line_t         wdata_q;
    line_be_t      be_q;
    line_t         ram_q;

    // Decode on line granularity; BASE is line-aligned so its low nibble never matters.
    logic [27:0] line_off;
    logic        in_range;
    assign line_off = avl_address[31:4] - BASE[31:4];
    assign in_range = (avl_address[31:4] >= BASE[31:4]) && (line_off < 28'(DEPTH));
    assign req      = avl_read | avl_write;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = err;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                    cnt_next   = CW'(LATENCY - 1);
                    if ((avl_address[3:0] != 4'd0) || (avl_read && avl_write) || !in_range) begin
                        err_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err   <= err_next;
        end
    end

    // Request fields are captured once; later changes by the master are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write   <= 1'b0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else if (accept) begin
            op_write   <= avl_write;
            in_range_q <= in_range;
            idx_q      <= line_off[IW-1:0];
            wdata_q    <= avl_writedata;
            be_q       <= avl_byteenable;
        end
    end

    // The read is launched on the final WAIT cycle so the registered RAM output lands in DONE.
    line_ram #(
        .DEPTH(DEPTH),
        .IW   (IW)
    ) u_ram (
        .clk    (clk),
        .addr   (idx_q),
        .rd_en  ((state == WAIT) && (cnt == '0) && req && in_range_q && !op_write),
        .wr_en  ((state == DONE) && op_write && in_range_q),
        .wr_data(wdata_q),
        .wr_be  (be_q),
        .rd_data(ram_q)
    );

    assign avl_waitrequest = (state != DONE);
    assign avl_readdata    = ((state == DONE) && !op_write && in_range_q) ? ram_q : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder against a line-array reference model.
module tb_mem_line_responder;
    import mem_line_responder_pkg::*;

    localparam int          DEPTH   = 256;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    line_t       avl_writedata;
    line_be_t    avl_byteenable;
    line_t       avl_readdata;
    logic        avl_waitrequest;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    line_t model_mem [DEPTH];
    logic  model_err;

    mem_line_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY),
        .BASE   (BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .avl_address    (avl_address),
        .avl_read       (avl_read),
        .avl_write      (avl_write),
        .avl_writedata  (avl_writedata),
        .avl_byteenable (avl_byteenable),
        .avl_readdata   (avl_readdata),
        .avl_waitrequest(avl_waitrequest),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic line_t merge(input line_t old, input line_t wd, input line_be_t be);
        line_t r;
        r = old;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        end
        return r;
    endfunction

    // Issue one transfer; cycles is the negedge count until waitrequest drops, -1 on timeout.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input line_t wd, input line_be_t be,
                        output line_t rdata, output int cycles);
        cycles = -1;
        rdata  = '0;
        @(negedge clk);
        avl_read       = rd;
        avl_write      = wr;
        avl_address    = addr;
        avl_writedata  = wd;
        avl_byteenable = be;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!avl_waitrequest) begin
                cycles = k;
                rdata  = avl_readdata;
                break;
            end
        end
        avl_read  = 1'b0;
        avl_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        avl_read       = 1'b0;
        avl_write      = 1'b0;
        avl_address    = '0;
        avl_writedata  = '0;
        avl_byteenable = '0;
        model_err      = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (avl_waitrequest !== 1'b1) $display("[TB] FAIL reset_waitrequest got %b want 1", avl_waitrequest);
        else n_pass++;
        n_total++;
        if (avl_readdata !== '0) $display("[TB] FAIL reset_readdata got %h want 0", avl_readdata);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", err);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_write_read();
        line_t d, rdata;
        int    cyc;
        d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        xfer(1'b0, 1'b1, 32'h20, d, 16'hFFFF, rdata, cyc);
        model_mem[2] = merge(model_mem[2], d, 16'hFFFF);
        n_total++;
        if (cyc !== LATENCY + 1) $display("[TB] FAIL write_latency got %0d want %0d", cyc, LATENCY + 1);
        else n_pass++;
        n_total++;
        if (rdata !== '0) $display("[TB] FAIL write_readdata_zero got %h want 0", rdata);
        else n_pass++;
        xfer(1'b1, 1'b0, 32'h20, '0, '0, rdata, cyc);
        n_total++;
        if (cyc !== LATENCY + 1) $display("[TB] FAIL read_latency got %0d want %0d", cyc, LATENCY + 1);
        else n_pass++;
        n_total++;
        if (rdata !== model_mem[2]) $display("[TB] FAIL read_full got %h want %h", rdata, model_mem[2]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (avl_readdata !== '0) $display("[TB] FAIL readdata_after_done got %h want 0", avl_readdata);
        else n_pass++;
        n_total++;
        if (err !== model_err) $display("[TB] FAIL err_clean got %b want %b", err, model_err);
        else n_pass++;
    endtask

    task automatic test_partial_write();
        line_t rdata;
        int    cyc;
        xfer(1'b0, 1'b1, 32'h20, {16{8'hAA}}, 16'h000F, rdata, cyc);
        model_mem[2] = merge(model_mem[2], {16{8'hAA}}, 16'h000F);
        xfer(1'b1, 1'b0, 32'h20, '0, '0, rdata, cyc);
        n_total++;
        if (rdata !== model_mem[2]) $display("[TB] FAIL partial_write got %h want %h", rdata, model_mem[2]);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        line_t rdata;
        int    cyc;
        xfer(1'b1, 1'b0, BASE + DEPTH * 16, '0, '0, rdata, cyc);
        model_err = 1'b1;
        n_total++;
        if (cyc !== LATENCY + 1) $display("[TB] FAIL oor_latency got %0d want %0d", cyc, LATENCY + 1);
        else n_pass++;
        n_total++;
        if (rdata !== '0) $display("[TB] FAIL oor_readdata got %h want 0", rdata);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_total++;
        if (err !== model_err) $display("[TB] FAIL oor_err_sticky got %b want %b", err, model_err);
        else n_pass++;
    endtask

    task automatic test_both_ops();
        line_t d, rdata;
        int    cyc;
        d = {$urandom, $urandom, $urandom, $urandom};
        xfer(1'b1, 1'b1, 32'h40, d, 16'hFFFF, rdata, cyc);
        model_mem[4] = d;
        n_total++;
        if (rdata !== '0) $display("[TB] FAIL both_ops_readdata got %h want 0", rdata);
        else n_pass++;
        xfer(1'b1, 1'b0, 32'h40, '0, '0, rdata, cyc);
        n_total++;
        if (rdata !== model_mem[4]) $display("[TB] FAIL both_ops_written got %h want %h", rdata, model_mem[4]);
        else n_pass++;
        n_total++;
        if (err !== model_err) $display("[TB] FAIL both_ops_err got %b want %b", err, model_err);
        else n_pass++;
    endtask

    task automatic test_abort();
        line_t rdata;
        int    cyc;
        logic  saw_low;
        saw_low = 1'b0;
        @(negedge clk);
        avl_read    = 1'b1;
        avl_address = 32'h20;
        @(negedge clk);
        avl_read = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!avl_waitrequest) saw_low = 1'b1;
        end
        n_total++;
        if (saw_low !== 1'b0) $display("[TB] FAIL abort_no_pulse got %b want 0", saw_low);
        else n_pass++;
        n_total++;
        if (err !== 1'b1) $display("[TB] FAIL abort_err got %b want 1", err);
        else n_pass++;
        xfer(1'b1, 1'b0, 32'h20, '0, '0, rdata, cyc);
        n_total++;
        if (rdata !== model_mem[2] || cyc !== LATENCY + 1)
            $display("[TB] FAIL abort_next_read got %h/%0d want %h/%0d", rdata, cyc, model_mem[2], LATENCY + 1);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        line_t old_line, rdata;
        int    cyc;
        old_line = {$urandom, $urandom, $urandom, $urandom};
        xfer(1'b0, 1'b1, 32'h60, old_line, 16'hFFFF, rdata, cyc);
        model_mem[6] = old_line;
        @(negedge clk);
        avl_write      = 1'b1;
        avl_address    = 32'h60;
        avl_writedata  = ~old_line;
        avl_byteenable = 16'hFFFF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_err = 1'b0;
        n_total++;
        if (avl_waitrequest !== 1'b1 || err !== model_err)
            $display("[TB] FAIL reset_mid_write got wr=%b err=%b want wr=1 err=0", avl_waitrequest, err);
        else n_pass++;
        @(negedge clk);
        avl_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b1, 1'b0, 32'h60, '0, '0, rdata, cyc);
        n_total++;
        if (rdata !== model_mem[6]) $display("[TB] FAIL reset_write_dropped got %h want %h", rdata, model_mem[6]);
        else n_pass++;
    endtask

    task automatic test_random();
        line_t    d, rdata, expd;
        line_be_t be;
        int       cyc, line, bad;
        logic     is_wr, misalign;
        logic [31:0] addr;
        bad = 0;
        for (int l = 0; l < 8; l++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            xfer(1'b0, 1'b1, BASE + l * 16, d, 16'hFFFF, rdata, cyc);
            model_mem[l] = d;
        end
        for (int n = 0; n < 40; n++) begin
            line     = $urandom_range(0, 7);
            is_wr    = 1'($urandom_range(0, 1));
            misalign = ($urandom_range(0, 9) == 0);
            addr     = BASE + line * 16 + (misalign ? $urandom_range(1, 15) : 0);
            d        = {$urandom, $urandom, $urandom, $urandom};
            be       = 16'($urandom);
            xfer(~is_wr, is_wr, addr, d, be, rdata, cyc);
            if (is_wr) begin
                model_mem[line] = merge(model_mem[line], d, be);
                expd = '0;
            end else begin
                expd = model_mem[line];
            end
            model_err = model_err | misalign;
            n_total++;
            if (rdata !== expd || cyc !== LATENCY + 1 || err !== model_err) begin
                $display("[TB] FAIL random_%0d got data=%h cyc=%0d err=%b want data=%h cyc=%0d err=%b",
                         n, rdata, cyc, err, expd, LATENCY + 1, model_err);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_out_of_range();
        test_both_ops();
        test_abort();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
